// File: rtl/risc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc16_pkg
//  Purpose  : Opcodes, sequencer states and datapath select encodings shared
//             by the RISC-16 sequencer, ALU, register-file mux and PC mux.
//  Revision : 1.0  initial release
// ============================================================================
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_NAND   = 2'd1;
    localparam logic [1:0] ALU_PASS_B = 2'd2;
    localparam logic [1:0] ALU_SUB    = 2'd3;

    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_MDR = 2'd1;
    localparam logic [1:0] WSRC_PC1 = 2'd2;
    localparam logic [1:0] WSRC_LUI = 2'd3;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;

    // Only stores and branches leave the register file untouched.
    function automatic logic writes_gpr(input logic [2:0] op);
        return (op != OP_SW) && (op != OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc16_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : risc16_wdog
//  Purpose  : Memory-wait watchdog; flags the cycle in which the count of
//             unacknowledged request cycles reaches TIMEOUT.
//  Revision : 1.0  initial release
// ============================================================================
module risc16_wdog #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // clr dominates inc, so an ack on the final wait cycle never expires.
    assign expired = inc && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : risc16_seq
//  Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the
//             RISC-16 core with a watchdog on every memory handshake.
//  Revision : 1.0  initial release
// ============================================================================
module risc16_seq
    import risc16_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        mem_ack,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        mdr_load,
    output logic [1:0]  alu_op,
    output logic        alu_bsel,
    output logic        gpr_write_en,
    output logic [1:0]  gpr_wsrc,
    output logic        pc_load,
    output logic [1:0]  pc_src,
    output logic        halted,
    output logic        bus_err
);

    state_t      state_q;
    state_t      state_d;
    logic        zero_q;
    logic [2:0]  w_op;
    logic [2:0]  w_ra;
    logic [6:0]  w_imm7;
    logic        w_waiting;
    logic        w_expired;
    logic        w_unused_ir;

    assign w_op        = ir[15:13];
    assign w_ra        = ir[12:10];
    assign w_imm7      = ir[6:0];
    assign w_unused_ir = ^ir[9:7];

    assign w_waiting = (state_q == S_FETCH) || (state_q == S_MEM);

    risc16_wdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_waiting || mem_ack),
        .inc     (w_waiting && !mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC) begin
                zero_q <= alu_zero;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        alu_op       = ALU_ADD;
        alu_bsel     = 1'b0;
        gpr_write_en = 1'b0;
        gpr_wsrc     = WSRC_ALU;
        pc_load      = 1'b0;
        pc_src       = PC_INC;
        halted       = 1'b0;
        bus_err      = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                if (mem_ack)        state_d = S_DECODE;
                else if (w_expired) state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_ADDI, OP_LW, OP_SW: alu_bsel = 1'b1;
                    OP_NAND:               alu_op   = ALU_NAND;
                    OP_LUI:                alu_op   = ALU_PASS_B;
                    OP_BEQ:                alu_op   = ALU_SUB;
                    default: ;
                endcase
                if (w_op == OP_LW || w_op == OP_SW)        state_d = S_MEM;
                else if (w_op == OP_JALR && w_imm7 != '0)  state_d = S_HALT;
                else                                       state_d = S_WB;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_op == OP_SW);
                mdr_load     = (w_op == OP_LW) && mem_ack;
                if (mem_ack)        state_d = S_WB;
                else if (w_expired) state_d = S_FAULT;
            end
            S_WB: begin
                pc_load = 1'b1;
                if (w_op == OP_BEQ && zero_q) pc_src = PC_BR;
                else if (w_op == OP_JALR)     pc_src = PC_REG;
                case (w_op)
                    OP_LW:   gpr_wsrc = WSRC_MDR;
                    OP_JALR: gpr_wsrc = WSRC_PC1;
                    OP_LUI:  gpr_wsrc = WSRC_LUI;
                    default: ;
                endcase
                gpr_write_en = writes_gpr(w_op) && (w_ra != 3'd0);
                state_d      = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            S_FAULT: bus_err = 1'b1;
            default: state_d = S_RST;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_risc16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc16_seq
//  Purpose  : Self-checking bench for risc16_seq: per-instruction expected
//             output traces built from the instruction-level rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_risc16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        mem_ack;
    logic        alu_zero;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, mdr_load;
    logic [1:0]  alu_op;
    logic        alu_bsel, gpr_write_en;
    logic [1:0]  gpr_wsrc;
    logic        pc_load;
    logic [1:0]  pc_src;
    logic        halted, bus_err;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    risc16_seq #(.TIMEOUT(4), .TW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .mem_ack      (mem_ack),
        .alu_zero     (alu_zero),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .mdr_load     (mdr_load),
        .alu_op       (alu_op),
        .alu_bsel     (alu_bsel),
        .gpr_write_en (gpr_write_en),
        .gpr_wsrc     (gpr_wsrc),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .halted       (halted),
        .bus_err      (bus_err)
    );

    assign obs = {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, alu_op, alu_bsel,
                  gpr_write_en, gpr_wsrc, pc_load, pc_src, halted, bus_err};

    // Bit positions within the packed observation vector.
    localparam logic [15:0] V_REQ  = 16'h8000;
    localparam logic [15:0] V_WE   = 16'h4000;
    localparam logic [15:0] V_ASEL = 16'h2000;
    localparam logic [15:0] V_IRL  = 16'h1000;
    localparam logic [15:0] V_MDRL = 16'h0800;
    localparam logic [15:0] V_PCL  = 16'h0010;
    localparam logic [15:0] V_HLT  = 16'h0002;
    localparam logic [15:0] V_BERR = 16'h0001;

    function automatic logic [15:0] v_alu(input int op, input bit bsel);
        return 16'((op & 3) << 9) | (bsel ? 16'h0100 : 16'h0000);
    endfunction

    function automatic logic [15:0] v_wb(input bit wen, input int wsrc, input int pcs);
        return V_PCL | (wen ? 16'h0080 : 16'h0000) | 16'((wsrc & 3) << 5) | 16'((pcs & 3) << 2);
    endfunction

    task automatic cyc(input logic ack, input logic z, input logic r,
                       input logic [15:0] exp, input string nm, output logic [15:0] got);
        mem_ack  = ack;
        alu_zero = z;
        rst      = r;
        @(negedge clk);
        got = obs;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        logic [15:0] g;
        ir  = 16'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b1, 16'h0, "rst_hold", g);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, "rst_release", g);
    endtask

    // Expected trace from the instruction rules; starts with the DUT in FETCH.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input bit z,
                             input string nm, output int wb_idx, output logic [15:0] wb_obs,
                             output bit stopped);
        logic [15:0] eq[$];
        bit          aq[$];
        bit          zq[$];
        logic [15:0] g;
        int op, ra, im, aop, wsrc, pcs;
        bit bsel, wen;
        op = int'(ins[15:13]); ra = int'(ins[12:10]); im = int'(ins[6:0]);
        stopped = 1'b0;
        for (int k = 0; k < fw; k++) begin eq.push_back(V_REQ); aq.push_back(0); zq.push_back(!z); end
        eq.push_back(V_REQ | V_IRL); aq.push_back(1); zq.push_back(!z);
        eq.push_back(16'h0);         aq.push_back(0); zq.push_back(!z);
        aop  = (op == 2) ? 1 : (op == 3) ? 2 : (op == 6) ? 3 : 0;
        bsel = (op == 1) || (op == 4) || (op == 5);
        eq.push_back(v_alu(aop, bsel)); aq.push_back(0); zq.push_back(z);
        if (op == 7 && im != 0) begin
            stopped = 1'b1;
            for (int k = 0; k < 3; k++) begin eq.push_back(V_HLT); aq.push_back(k[0]); zq.push_back(z); end
        end else begin
            if (op == 4 || op == 5) begin
                for (int k = 0; k < mw; k++) begin
                    eq.push_back(V_REQ | V_ASEL | (op == 4 ? V_WE : 16'h0)); aq.push_back(0); zq.push_back(!z);
                end
                eq.push_back(V_REQ | V_ASEL | (op == 4 ? V_WE : V_MDRL)); aq.push_back(1); zq.push_back(!z);
            end
            wsrc = (op == 5) ? 1 : (op == 7) ? 2 : (op == 3) ? 3 : 0;
            pcs  = (op == 6 && z) ? 1 : (op == 7) ? 2 : 0;
            wen  = (op != 4) && (op != 6) && (ra != 0);
            eq.push_back(v_wb(wen, wsrc, pcs)); aq.push_back(0); zq.push_back(!z);
        end
        ir = ins;
        wb_idx = -1;
        wb_obs = 16'h0;
        foreach (eq[i]) begin
            cyc(aq[i], zq[i], 1'b0, eq[i], $sformatf("%s c%0d", nm, i), g);
            if (wb_idx < 0 && g[4] === 1'b1) begin
                wb_idx = i;
                wb_obs = g;
            end
        end
    endtask

    typedef struct {
        logic [15:0] ins;
        int          fw;
        int          mw;
        bit          z;
        int          len;
        logic [15:0] wb;
        string       nm;
    } vec_t;

    initial begin
        vec_t        tbl[12];
        int          wi;
        logic [15:0] wo, g;
        bit          st;

        tbl[0]  = '{16'h0503, 0, 0, 1'b0, 4, 16'h0090, "add_r1"};
        tbl[1]  = '{16'hA985, 0, 3, 1'b0, 8, 16'h00B0, "lw_wait3"};
        tbl[2]  = '{16'hC483, 0, 0, 1'b1, 4, 16'h0014, "beq_taken"};
        tbl[3]  = '{16'hC483, 0, 0, 1'b0, 4, 16'h0010, "beq_not"};
        tbl[4]  = '{16'h0082, 0, 0, 1'b0, 4, 16'h0010, "add_r0"};
        tbl[5]  = '{16'h32FF, 3, 0, 1'b0, 7, 16'h0090, "addi_fw3"};
        tbl[6]  = '{16'h5F05, 1, 0, 1'b1, 5, 16'h0090, "nand"};
        tbl[7]  = '{16'h6D55, 0, 0, 1'b0, 4, 16'h00F0, "lui"};
        tbl[8]  = '{16'h8502, 1, 2, 1'b0, 8, 16'h0010, "sw"};
        tbl[9]  = '{16'hE500, 0, 0, 1'b0, 4, 16'h00D8, "jalr"};
        tbl[10] = '{16'hA081, 2, 1, 1'b0, 8, 16'h0030, "lw_r0"};
        tbl[11] = '{16'h8502, 0, 3, 1'b1, 8, 16'h0010, "sw_mw3"};

        mem_ack = 1'b0; alu_zero = 1'b0; rst = 1'b1; ir = 16'h0;
        reset_seq();

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].z, tbl[i].nm, wi, wo, st);
            total++;
            if (wi + 1 != tbl[i].len || wo !== tbl[i].wb) begin
                bad++;
                $display("FAIL tbl_%s: got len=%0d wb=%h want len=%0d wb=%h",
                         tbl[i].nm, wi + 1, wo, tbl[i].len, tbl[i].wb);
            end
        end

        // JALR with nonzero imm halts; halted stays and no request follows.
        run_instr(16'hE001, 0, 0, 1'b0, "halt", wi, wo, st);
        cyc(1'b1, 1'b0, 1'b0, V_HLT, "halt_sticky", g);
        reset_seq();

        // Fetch never acknowledged: four waiting cycles, then sticky bus error.
        ir = 16'h0503;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, V_REQ, $sformatf("wd_wait%0d", k), g);
        cyc(1'b0, 1'b0, 1'b0, V_BERR, "wd_fault", g);
        cyc(1'b1, 1'b0, 1'b0, V_BERR, "wd_sticky", g);
        reset_seq();

        // Reset in the middle of a load's memory wait.
        ir = 16'hA985;
        cyc(1'b1, 1'b0, 1'b0, V_REQ | V_IRL, "mr_fetch", g);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, "mr_decode", g);
        cyc(1'b0, 1'b0, 1'b0, v_alu(0, 1'b1), "mr_exec", g);
        cyc(1'b0, 1'b0, 1'b0, V_REQ | V_ASEL, "mr_mem", g);
        cyc(1'b0, 1'b0, 1'b1, V_REQ | V_ASEL, "mr_rst_edge", g);
        cyc(1'b1, 1'b0, 1'b1, 16'h0, "mr_in_rst", g);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, "mr_rst_low", g);
        cyc(1'b1, 1'b0, 1'b0, V_REQ | V_IRL, "mr_refetch", g);
        reset_seq();

        for (int n = 0; n < 60; n++) begin
            run_instr(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), wi, wo, st);
            if (st) reset_seq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
